// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision constants, divider FSM states
// and small operand helpers used by the arithmetic units.
package fpu_pkg;

  localparam int          EXP_BIAS     = 127;
  localparam logic [31:0] QNAN_DEFAULT = 32'h7fffffff;
  localparam logic [31:0] POS_INF      = 32'h7f800000;

  typedef enum logic [3:0] {
    ST_READY,
    ST_DIVIDE,
    ST_NORMALIZE,
    ST_VALIDATE_RESULT,
    ST_INVALID,
    ST_SPECIAL_INF,
    ST_SPECIAL_ZERO,
    ST_DIV_ZERO,
    ST_DONE
  } div_state_e;

  // Subnormals are flushed, so a zero biased exponent means zero.
  function automatic logic is_zero(input logic [7:0] exp_val);
    return exp_val == 8'd0;
  endfunction

endpackage

// File: rtl/divider_core.sv
// Restoring significand divider: one quotient bit per cycle, producing
// floor(dividend * 2^(QUOT_BITS-1) / divisor).
module divider_core #(
  parameter int QUOT_BITS = 25
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 start,
  input  logic [23:0]          dividend,
  input  logic [23:0]          divisor,
  output logic [QUOT_BITS-1:0] quotient,
  output logic                 done
);

  logic [25:0]          rem_reg;
  logic [23:0]          div_reg;
  logic [QUOT_BITS-1:0] quot_reg;
  logic [4:0]           count_reg;
  logic                 run_reg;

  logic [25:0] div_ext;
  logic [25:0] diff;
  logic        rem_ge;

  assign div_ext  = {2'b00, div_reg};
  assign diff     = rem_reg - div_ext;
  assign rem_ge   = rem_reg >= div_ext;
  assign quotient = quot_reg;
  // High during the cycle whose closing edge writes the final quotient bit,
  // so the caller can leave its wait state on that same edge.
  assign done     = run_reg && (count_reg == 5'(QUOT_BITS - 1));

  always_ff @(posedge clk) begin
    if (srst) begin
      rem_reg   <= '0;
      div_reg   <= '0;
      quot_reg  <= '0;
      count_reg <= '0;
      run_reg   <= 1'b0;
    end else if (start) begin
      rem_reg   <= {2'b00, dividend};
      div_reg   <= divisor;
      quot_reg  <= '0;
      count_reg <= '0;
      run_reg   <= 1'b1;
    end else if (run_reg) begin
      if (rem_ge) begin
        quot_reg <= {quot_reg[QUOT_BITS-2:0], 1'b1};
        rem_reg  <= {diff[24:0], 1'b0};
      end else begin
        quot_reg <= {quot_reg[QUOT_BITS-2:0], 1'b0};
        rem_reg  <= {rem_reg[24:0], 1'b0};
      end
      count_reg <= count_reg + 5'd1;
      if (done) run_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_divider.sv
// Single-precision divider on decomposed operands: special-case dispatch,
// iterative significand division, normalization and range checking.
module fp_divider
  import fpu_pkg::*;
#(
  parameter logic [31:0] QNAN      = QNAN_DEFAULT,
  parameter int          QUOT_BITS = 25
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_valid_i,
  output logic        data_valid_o,
  output logic        busy_o,
  input  logic        x_sign_i,
  input  logic        y_sign_i,
  input  logic [7:0]  x_exp_i,
  input  logic [7:0]  y_exp_i,
  input  logic [22:0] x_frac_i,
  input  logic [22:0] y_frac_i,
  input  logic        x_infinity_i,
  input  logic        y_infinity_i,
  input  logic        x_nan_i,
  input  logic        y_nan_i,
  output logic [31:0] z_o,
  output logic        except_invalid_operation_o,
  output logic        except_divide_by_zero_o,
  output logic        except_overflow_o,
  output logic        except_underflow_o
);

  div_state_e         state_reg;
  div_state_e         accept_state;
  logic               sign_reg;
  logic signed [9:0]  exp_reg;
  logic [22:0]        frac_reg;
  logic [31:0]        res_z_reg;
  logic               res_invalid_reg;
  logic               res_dbz_reg;
  logic               res_ovf_reg;
  logic               res_unf_reg;

  logic                 x_zero;
  logic                 y_zero;
  logic                 accept;
  logic                 core_start;
  logic                 core_done;
  logic [QUOT_BITS-1:0] quotient;

  assign x_zero     = is_zero(x_exp_i);
  assign y_zero     = is_zero(y_exp_i);
  assign accept     = (state_reg == ST_READY) && data_valid_i;
  assign core_start = accept && (accept_state == ST_DIVIDE);
  assign busy_o     = (state_reg != ST_READY);

  // First matching case wins; NaN and indeterminate forms take priority.
  always_comb begin
    accept_state = ST_DIVIDE;
    if (x_nan_i || y_nan_i)
      accept_state = ST_INVALID;
    else if ((x_infinity_i && y_infinity_i) || (x_zero && y_zero))
      accept_state = ST_INVALID;
    else if (x_infinity_i)
      accept_state = ST_SPECIAL_INF;
    else if (y_infinity_i)
      accept_state = ST_SPECIAL_ZERO;
    else if (y_zero)
      accept_state = ST_DIV_ZERO;
    else if (x_zero)
      accept_state = ST_SPECIAL_ZERO;
  end

  divider_core #(
    .QUOT_BITS (QUOT_BITS)
  ) u_core (
    .clk      (clk_i),
    .srst     (rst_i),
    .start    (core_start),
    .dividend ({1'b1, x_frac_i}),
    .divisor  ({1'b1, y_frac_i}),
    .quotient (quotient),
    .done     (core_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg                  <= ST_READY;
      sign_reg                   <= 1'b0;
      exp_reg                    <= '0;
      frac_reg                   <= '0;
      res_z_reg                  <= '0;
      res_invalid_reg            <= 1'b0;
      res_dbz_reg                <= 1'b0;
      res_ovf_reg                <= 1'b0;
      res_unf_reg                <= 1'b0;
      z_o                        <= '0;
      data_valid_o               <= 1'b0;
      except_invalid_operation_o <= 1'b0;
      except_divide_by_zero_o    <= 1'b0;
      except_overflow_o          <= 1'b0;
      except_underflow_o         <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      case (state_reg)
        ST_READY: begin
          if (data_valid_i) begin
            sign_reg        <= x_sign_i ^ y_sign_i;
            exp_reg         <= $signed({2'b00, x_exp_i}) - $signed({2'b00, y_exp_i})
                               + 10'(EXP_BIAS);
            res_invalid_reg <= 1'b0;
            res_dbz_reg     <= 1'b0;
            res_ovf_reg     <= 1'b0;
            res_unf_reg     <= 1'b0;
            state_reg       <= accept_state;
          end
        end
        ST_DIVIDE: begin
          if (core_done) state_reg <= ST_NORMALIZE;
        end
        ST_NORMALIZE: begin
          // Quotient lies in [2^23, 2^25); the top bit selects the shift.
          if (quotient[QUOT_BITS-1]) begin
            frac_reg <= quotient[23:1];
          end else begin
            frac_reg <= quotient[22:0];
            exp_reg  <= exp_reg - 10'sd1;
          end
          state_reg <= ST_VALIDATE_RESULT;
        end
        ST_VALIDATE_RESULT: begin
          if (exp_reg >= 10'sd255) begin
            res_z_reg   <= {sign_reg, POS_INF[30:0]};
            res_ovf_reg <= 1'b1;
          end else if (exp_reg <= 10'sd0) begin
            res_z_reg   <= {sign_reg, 31'd0};
            res_unf_reg <= 1'b1;
          end else begin
            res_z_reg   <= {sign_reg, exp_reg[7:0], frac_reg};
          end
          state_reg <= ST_DONE;
        end
        ST_INVALID: begin
          res_z_reg       <= QNAN;
          res_invalid_reg <= 1'b1;
          state_reg       <= ST_DONE;
        end
        ST_SPECIAL_INF: begin
          res_z_reg <= {sign_reg, POS_INF[30:0]};
          state_reg <= ST_DONE;
        end
        ST_SPECIAL_ZERO: begin
          res_z_reg <= {sign_reg, 31'd0};
          state_reg <= ST_DONE;
        end
        ST_DIV_ZERO: begin
          res_z_reg   <= {sign_reg, POS_INF[30:0]};
          res_dbz_reg <= 1'b1;
          state_reg   <= ST_DONE;
        end
        ST_DONE: begin
          z_o                        <= res_z_reg;
          except_invalid_operation_o <= res_invalid_reg;
          except_divide_by_zero_o    <= res_dbz_reg;
          except_overflow_o          <= res_ovf_reg;
          except_underflow_o         <= res_unf_reg;
          data_valid_o               <= 1'b1;
          state_reg                  <= ST_READY;
        end
        default: state_reg <= ST_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: expected results are queued when operands are
// driven and compared (value, flags, latency) when data_valid_o pulses.
module tb_fp_divider;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_valid_i;
  logic        data_valid_o;
  logic        busy_o;
  logic        x_sign_i, y_sign_i;
  logic [7:0]  x_exp_i, y_exp_i;
  logic [22:0] x_frac_i, y_frac_i;
  logic        x_infinity_i, y_infinity_i;
  logic        x_nan_i, y_nan_i;
  logic [31:0] z_o;
  logic        except_invalid_operation_o;
  logic        except_divide_by_zero_o;
  logic        except_overflow_o;
  logic        except_underflow_o;

  typedef struct packed {
    logic [3:0]  flags;   // invalid, divide_by_zero, overflow, underflow
    logic [31:0] z;
    logic [5:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fp_divider dut (
    .clk_i                      (clk_i),
    .rst_i                      (rst_i),
    .data_valid_i               (data_valid_i),
    .data_valid_o               (data_valid_o),
    .busy_o                     (busy_o),
    .x_sign_i                   (x_sign_i),
    .y_sign_i                   (y_sign_i),
    .x_exp_i                    (x_exp_i),
    .y_exp_i                    (y_exp_i),
    .x_frac_i                   (x_frac_i),
    .y_frac_i                   (y_frac_i),
    .x_infinity_i               (x_infinity_i),
    .y_infinity_i               (y_infinity_i),
    .x_nan_i                    (x_nan_i),
    .y_nan_i                    (y_nan_i),
    .z_o                        (z_o),
    .except_invalid_operation_o (except_invalid_operation_o),
    .except_divide_by_zero_o    (except_divide_by_zero_o),
    .except_overflow_o          (except_overflow_o),
    .except_underflow_o         (except_underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    logic        s, xinf, yinf, xnan, ynan, xz, yz;
    logic [63:0] a, b, q;
    int          e;
    s    = x[31] ^ y[31];
    xinf = (x[30:23] == 8'hff) && (x[22:0] == 0);
    yinf = (y[30:23] == 8'hff) && (y[22:0] == 0);
    xnan = (x[30:23] == 8'hff) && (x[22:0] != 0);
    ynan = (y[30:23] == 8'hff) && (y[22:0] != 0);
    xz   = (x[30:23] == 8'h00);
    yz   = (y[30:23] == 8'h00);
    r.lat = 6'd2;
    if (xnan || ynan || (xinf && yinf) || (xz && yz)) begin
      r.flags = 4'b1000; r.z = 32'h7fffffff;
    end else if (xinf) begin
      r.flags = 4'b0000; r.z = {s, 8'hff, 23'd0};
    end else if (yinf || xz) begin
      r.flags = 4'b0000; r.z = {s, 31'd0};
    end else if (yz) begin
      r.flags = 4'b0100; r.z = {s, 8'hff, 23'd0};
    end else begin
      r.lat = 6'd28;
      a = {40'd0, 1'b1, x[22:0]};
      b = {40'd0, 1'b1, y[22:0]};
      q = (a << 24) / b;
      e = int'(x[30:23]) - int'(y[30:23]) + 127;
      if (q[24]) r.z = {s, 8'd0, q[23:1]};
      else begin r.z = {s, 8'd0, q[22:0]}; e = e - 1; end
      r.flags = 4'b0000;
      if (e >= 255) begin r.flags = 4'b0010; r.z = {s, 8'hff, 23'd0}; end
      else if (e <= 0) begin r.flags = 4'b0001; r.z = {s, 31'd0}; end
      else r.z[30:23] = 8'(e);
    end
    return r;
  endfunction

  task automatic drive_operands(input logic [31:0] x, input logic [31:0] y);
    x_sign_i     = x[31];  y_sign_i     = y[31];
    x_exp_i      = x[30:23]; y_exp_i    = y[30:23];
    x_frac_i     = x[22:0];  y_frac_i   = y[22:0];
    x_infinity_i = (x[30:23] == 8'hff) && (x[22:0] == 0);
    y_infinity_i = (y[30:23] == 8'hff) && (y[22:0] == 0);
    x_nan_i      = (x[30:23] == 8'hff) && (x[22:0] != 0);
    y_nan_i      = (y[30:23] == 8'hff) && (y[22:0] != 0);
  endtask

  // Drives one operation; returns right after the accepting edge (+1).
  task automatic send(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk_i);
    drive_operands(x, y);
    data_valid_i = 1'b1;
    exp_q.push_back(model(x, y));
    @(posedge clk_i); #1;
    data_valid_i = 1'b0;
  endtask

  // Waits for the result; optionally pulses data_valid_i with other operands mid-divide.
  task automatic collect(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input bit inject);
    int   n = 0;
    int   busy_low = 0;
    exp_t e;
    if (busy_o !== 1'b1) busy_low++;
    while (1) begin
      @(posedge clk_i); #1;
      n++;
      if (inject && n == 10) begin
        drive_operands(32'h41200000, 32'h40a00000);
        data_valid_i = 1'b1;
      end
      if (inject && n == 11) data_valid_i = 1'b0;
      if (data_valid_o === 1'b1) break;
      if (busy_o !== 1'b1) busy_low++;
      if (n > 40) break;
    end
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 64'(exp_q.size()), 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " valid"}, 64'(data_valid_o), 64'd1);
    check({tag, " z"}, 64'(z_o), 64'(e.z));
    check({tag, " flags"}, 64'({except_invalid_operation_o, except_divide_by_zero_o,
                                except_overflow_o, except_underflow_o}), 64'(e.flags));
    check({tag, " latency"}, 64'(n), 64'(e.lat));
    check({tag, " busy"}, 64'(busy_low), 64'd0);
    $display("op %s: %h / %h -> z=%h flags=%b after %0d cycles", tag, x, y, z_o,
             {except_invalid_operation_o, except_divide_by_zero_o,
              except_overflow_o, except_underflow_o}, n);
    @(posedge clk_i); #1;
    check({tag, " pulse"}, 64'(data_valid_o), 64'd0);
    check({tag, " hold"}, 64'(z_o), 64'(e.z));
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
    send(x, y);
    collect(tag, x, y, 1'b0);
  endtask

  initial begin
    int extra;
    logic [31:0] rx, ry;
    rst_i = 1'b1;
    data_valid_i = 1'b0;
    drive_operands(32'd0, 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    check("reset z", 64'(z_o), 64'd0);
    check("reset valid", 64'(data_valid_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset flags", 64'({except_invalid_operation_o, except_divide_by_zero_o,
                              except_overflow_o, except_underflow_o}), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    run_op("6div2",    32'h40c00000, 32'h40000000);
    run_op("1div3",    32'h3f800000, 32'h40400000);
    run_op("neg_dbz",  32'hbf800000, 32'h00000000);
    run_op("0div0",    32'h00000000, 32'h00000000);
    run_op("infdivinf",32'h7f800000, 32'hff800000);
    run_op("nan",      32'h7fc00001, 32'h3f800000);
    run_op("infdiv",   32'hff800000, 32'h40000000);
    run_op("divinf",   32'h40000000, 32'hff800000);
    run_op("zerodiv",  32'h80000000, 32'h40000000);
    run_op("subnorm",  32'h00400000, 32'h3f800000);
    run_op("overflow", 32'h7f000000, 32'h3e800000);
    run_op("underflow",32'h00800000, 32'h40000000);
    run_op("neg_frac", 32'hc0490fdb, 32'h402df854);

    for (int i = 0; i < 6; i++) begin
      rx = {1'($urandom), 8'($urandom_range(90, 160)), 23'($urandom)};
      ry = {1'($urandom), 8'($urandom_range(90, 160)), 23'($urandom)};
      run_op("random", rx, ry);
    end

    // Operands presented while busy must be dropped without a second result.
    send(32'h40c00000, 32'h40000000);
    collect("ignore_busy", 32'h40c00000, 32'h40000000, 1'b1);
    extra = 0;
    repeat (35) begin
      @(posedge clk_i); #1;
      if (data_valid_o === 1'b1) extra++;
    end
    check("ignore_busy extra", 64'(extra), 64'd0);

    // Reset during DIVIDE aborts without a result and clears the outputs.
    send(32'h3f800000, 32'h40400000);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("abort z", 64'(z_o), 64'd0);
    check("abort busy", 64'(busy_o), 64'd0);
    check("abort valid", 64'(data_valid_o), 64'd0);
    check("abort flags", 64'({except_invalid_operation_o, except_divide_by_zero_o,
                              except_overflow_o, except_underflow_o}), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    void'(exp_q.pop_front());
    extra = 0;
    repeat (35) begin
      @(posedge clk_i); #1;
      if (data_valid_o === 1'b1) extra++;
    end
    check("abort no_pulse", 64'(extra), 64'd0);
    run_op("after_abort", 32'h40c00000, 32'h40000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
